// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, widths and an opcode legality helper.
package alu_pkg;

  localparam int ALU_CTL_W = 5;
  localparam int XLEN      = 32;

  // Opcodes 0..15 are defined; anything with the top bit set is illegal.
  typedef enum logic [ALU_CTL_W-1:0] {
    ALU_AND   = 5'd0,
    ALU_OR    = 5'd1,
    ALU_ADD   = 5'd2,
    ALU_XOR   = 5'd3,
    ALU_SLL   = 5'd4,
    ALU_SRL   = 5'd5,
    ALU_SUB   = 5'd6,
    ALU_SLT   = 5'd7,
    ALU_SGE   = 5'd8,
    ALU_PASSA = 5'd9,
    ALU_PASSB = 5'd10,
    ALU_EQ    = 5'd11,
    ALU_NE    = 5'd12,
    ALU_SLTU  = 5'd13,
    ALU_SGEU  = 5'd14,
    ALU_SRA   = 5'd15
  } alu_op_e;

  // An opcode is legal when it falls inside the 16 defined operations.
  function automatic logic is_legal_op(input logic [ALU_CTL_W-1:0] op);
    return !op[ALU_CTL_W-1];
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; illegal opcodes produce 0 (so Zero=1).
module alu
  import alu_pkg::*;
(
  input  logic [ALU_CTL_W-1:0] ctl,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  output logic [XLEN-1:0]      result,
  output logic                 zero
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation decode; compares return 0/1 in bit 0.
  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SUB:   result = a - b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) <  $signed(b))};
      ALU_SGE:   result = {{(XLEN-1){1'b0}}, ($signed(a) >= $signed(b))};
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      ALU_EQ:    result = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_NE:    result = {{(XLEN-1){1'b0}}, (a != b)};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a <  b)};
      ALU_SGEU:  result = {{(XLEN-1){1'b0}}, (a >= b)};
      ALU_SRA:   result = XLEN'($signed(a) >>> shamt);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap, grants at most
// one requester when enabled, and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  // Rotating priority search; the winner index is valid even when en=0 so the
  // datapath mux never depends on the output stage state.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int cand;
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    gnt_valid = found && en;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  // Pointer advances past the granted requester; held when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters; the granted operation's result is held
// in a single output register tagged with its owner and returned by valid/ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ALU_CTL_W-1:0] req_ctl,
  input  logic [N_REQ*XLEN-1:0]      req_a,
  input  logic [N_REQ*XLEN-1:0]      req_b,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [XLEN-1:0]            resp_data,
  output logic                       resp_zero,
  output logic                       resp_illegal,
  output logic [IDX_W-1:0]           resp_id,
  output logic [31:0]                busy_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_id_q, out_id_d;
  logic [XLEN-1:0]      resp_data_q, resp_data_d;
  logic                 resp_zero_q, resp_zero_d;
  logic                 resp_illegal_q, resp_illegal_d;
  logic [31:0]          busy_cnt_q, busy_cnt_d;

  logic                 can_accept;
  logic                 consumed;
  logic [N_REQ-1:0]     gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [ALU_CTL_W-1:0] alu_ctl;
  logic [XLEN-1:0]      alu_a, alu_b, alu_result;
  logic                 alu_zero;

  // The held result leaves this cycle if its owner is ready, which frees the
  // register for a new grant in the same cycle.
  assign consumed   = out_valid_q && resp_ready[out_id_q];
  assign can_accept = !out_valid_q || consumed;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_valid),
    .en        (can_accept),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = gnt;

  // Steer the winning requester's opcode and operands into the ALU.
  always_comb begin
    alu_ctl = req_ctl[gnt_idx*ALU_CTL_W +: ALU_CTL_W];
    alu_a   = req_a[gnt_idx*XLEN +: XLEN];
    alu_b   = req_b[gnt_idx*XLEN +: XLEN];
  end

  alu u_alu (
    .ctl    (alu_ctl),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Output register next state: load on grant, clear on consume, else hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_id_d       = out_id_q;
    resp_data_d    = resp_data_q;
    resp_zero_d    = resp_zero_q;
    resp_illegal_d = resp_illegal_q;
    busy_cnt_d     = busy_cnt_q;
    if (gnt_valid) begin
      out_valid_d    = 1'b1;
      out_id_d       = gnt_idx;
      resp_data_d    = alu_result;
      resp_zero_d    = alu_zero;
      resp_illegal_d = !is_legal_op(alu_ctl);
      busy_cnt_d     = busy_cnt_q + 32'd1;
    end else if (consumed) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and grant counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q    <= 1'b0;
      out_id_q       <= '0;
      resp_data_q    <= '0;
      resp_zero_q    <= 1'b0;
      resp_illegal_q <= 1'b0;
      busy_cnt_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_id_q       <= out_id_d;
      resp_data_q    <= resp_data_d;
      resp_zero_q    <= resp_zero_d;
      resp_illegal_q <= resp_illegal_d;
      busy_cnt_q     <= busy_cnt_d;
    end
  end

  // One-hot response valid decoded from the owner tag.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp_valid
      assign resp_valid[gi] = out_valid_q && (out_id_q == IDX_W'(gi));
    end
  endgenerate

  assign resp_data    = resp_data_q;
  assign resp_zero    = resp_zero_q;
  assign resp_illegal = resp_illegal_q;
  assign resp_id      = out_id_q;
  assign busy_cnt     = busy_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester ALU operations plus
// hand sequences for round-robin order, backpressure and mid-operation reset.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_ctl;
  logic [N*XL-1:0] req_a;
  logic [N*XL-1:0] req_b;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [XL-1:0]   resp_data;
  logic            resp_zero;
  logic            resp_illegal;
  logic [1:0]      resp_id;
  logic [31:0]     busy_cnt;

  int n_pass  = 0;
  int n_total = 0;

  alu_arbiter #(.N_REQ(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctl      (req_ctl),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_zero    (resp_zero),
    .resp_illegal (resp_illegal),
    .resp_id      (resp_id),
    .busy_cnt     (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic [4:0] ctl, input logic [31:0] a,
                         input logic [31:0] b);
    req_ctl[5*r +: 5]  = ctl;
    req_a[XL*r +: XL]  = a;
    req_b[XL*r +: XL]  = b;
  endtask

  initial begin
    logic [3:0] onehot;
    int         exp_busy;

    // Vector table: requester, opcode, A, B, expected data, zero, illegal.
    vecs[0]  = '{1, 5'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{2, 5'd15, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0};
    vecs[2]  = '{0, 5'd7,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{0, 5'd13, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{3, 5'd20, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b1};
    vecs[5]  = '{0, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[6]  = '{1, 5'd1,  32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0};
    vecs[7]  = '{2, 5'd3,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};
    vecs[8]  = '{3, 5'd4,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
    vecs[9]  = '{0, 5'd5,  32'h80000000, 32'h00000023, 32'h10000000, 1'b0, 1'b0};
    vecs[10] = '{1, 5'd6,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[11] = '{2, 5'd8,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{3, 5'd9,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0};
    vecs[13] = '{0, 5'd10, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{1, 5'd11, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0};
    vecs[15] = '{2, 5'd12, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vecs[16] = '{3, 5'd14, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[17] = '{0, 5'd31, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1};

    rstn       = 1'b0;
    req_valid  = '0;
    req_ctl    = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    exp_busy   = 0;

    // Reset state.
    #3;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_zero", 32'(resp_zero), 32'h0);
    check("rst_resp_illegal", 32'(resp_illegal), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_busy_cnt", busy_cnt, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Round robin: all four valid, consumer always ready; grants 0,1,2,3,0,...
    for (int i = 0; i < N; i++) set_req(i, 5'd2, 32'(100 + i), 32'(i));
    req_valid = '1;
    for (int k = 0; k <= 8; k++) begin
      #1;
      if (k < 8) begin
        onehot = 4'b0001 << (k % 4);
        check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(onehot));
      end
      if (k > 0) begin
        onehot = 4'b0001 << ((k - 1) % 4);
        check($sformatf("rr_resp_valid_%0d", k), 32'(resp_valid), 32'(onehot));
        check($sformatf("rr_resp_id_%0d", k), 32'(resp_id), 32'((k - 1) % 4));
        check($sformatf("rr_resp_data_%0d", k), resp_data, 32'(100 + 2 * ((k - 1) % 4)));
      end
      if (k == 8) break;
      @(posedge clk);
      exp_busy++;
      @(negedge clk);
    end
    check("rr_busy_cnt", busy_cnt, 32'd8);
    req_valid = '0;
    @(negedge clk);

    // Table vectors, one requester at a time.
    for (int v = 0; v < 18; v++) begin
      set_req(vecs[v].r, vecs[v].ctl, vecs[v].a, vecs[v].b);
      onehot    = 4'b0001 << vecs[v].r;
      req_valid = onehot;
      #1;
      check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(onehot));
      @(posedge clk);
      exp_busy++;
      #1;
      req_valid = '0;
      check($sformatf("v%0d_resp_valid", v), 32'(resp_valid), 32'(onehot));
      check($sformatf("v%0d_resp_data", v), resp_data, vecs[v].d);
      check($sformatf("v%0d_resp_zero", v), 32'(resp_zero), 32'(vecs[v].z));
      check($sformatf("v%0d_resp_illegal", v), 32'(resp_illegal), 32'(vecs[v].ill));
      check($sformatf("v%0d_resp_id", v), 32'(resp_id), 32'(vecs[v].r));
      @(negedge clk);
    end
    @(negedge clk);
    check("tbl_busy_cnt", busy_cnt, 32'(exp_busy));
    check("tbl_drained", 32'(resp_valid), 32'h0);

    // Backpressure: req0 sub 3-5 held while nobody consumes; req3 waits.
    resp_ready = '0;
    set_req(0, 5'd6, 32'd3, 32'd5);
    req_valid = 4'b0001;
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(3, 5'd2, 32'd10, 32'd20);
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_ready_%0d", c), 32'(req_ready), 32'h0);
      check($sformatf("bp_hold_valid_%0d", c), 32'(resp_valid), 32'h1);
      check($sformatf("bp_hold_data_%0d", c), resp_data, 32'hFFFFFFFE);
    end
    resp_ready = 4'b0001;
    #1;
    check("bp_passthru_grant3", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    req_valid  = '0;
    resp_ready = '1;
    check("bp_r3_valid", 32'(resp_valid), 32'h8);
    check("bp_r3_data", resp_data, 32'd30);
    check("bp_r3_id", 32'(resp_id), 32'd3);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of an outstanding result.
    resp_ready = '0;
    set_req(0, 5'd2, 32'd5, 32'd7);
    req_valid = 4'b0001;
    @(posedge clk);
    #1;
    req_valid = '0;
    check("mid_resp_valid", 32'(resp_valid), 32'h1);
    check("mid_resp_data", resp_data, 32'd12);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_busy_cnt", busy_cnt, 32'h0);
    check("mid_rst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    resp_ready = '1;
    req_valid  = '1;
    #1;
    check("post_rst_ptr0", 32'(req_ready), 32'h1);
    set_req(2, 5'd6, 32'd9, 32'd4);
    req_valid = 4'b0100;
    #1;
    check("post_rst_grant2", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("post_rst_valid", 32'(resp_valid), 32'h4);
    check("post_rst_data", resp_data, 32'd5);
    check("post_rst_id", 32'(resp_id), 32'd2);
    check("post_rst_busy", busy_cnt, 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 32-bit integer ALU among N_REQ requesters, e.g. integer pipe, address-generation and branch-compare ports. Each cycle a round-robin arbiter grants one valid request and drives the ALU combinationally. The result is captured in a single output register tagged with the owner's index. That register is returned over a per-requester valid/ready handshake.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(N_REQ), requester index width
XLEN, 32, operand/result width; fixed to match the ALU

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  N_REQ  request i presents an operation
req_ready  output  N_REQ  one-hot grant; request i is accepted this cycle
req_ctl  input  N_REQ*5  ALU opcode per requester, slice i = [5i+4:5i]
req_a  input  N_REQ*XLEN  operand A per requester
req_b  input  N_REQ*XLEN  operand B per requester
resp_valid  output  N_REQ  one-hot; result held for requester i
resp_ready  input  N_REQ  requester i consumes the result
resp_data  output  XLEN  registered ALU result
resp_zero  output  1  registered ALU Zero flag
resp_illegal  output  1  registered: opcode was > 15 (result forced 0)
resp_id  output  IDX_W  owner index of the held result
busy_cnt  output  32  count of cycles in which a grant occurred; wraps

Behaviour:
- Reset (rstn low, asynchronous): out_valid=0, resp_valid=0, resp_data=0, resp_zero=0, resp_illegal=0, resp_id=0, rr_ptr=0, busy_cnt=0. Any in-flight result is discarded, with no partial response.
- Output stage free: can_accept = !out_valid | resp_ready[out_id]. Pass-through draining in the same cycle is allowed.
- Grant selection: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - Grant is asserted only when can_accept=1.
  - req_ready is purely combinational from req_valid, rr_ptr and the output state. It is at most one-hot.
  - req_ready must not depend on req_ctl, req_a or req_b.
- On grant of i:
  - The ALU is driven with slice i.
  - Next edge: resp_data=ALUOut, resp_zero=Zero, resp_illegal=(ctl[4]=1), resp_id=i, out_valid=1.
  - rr_ptr becomes (i+1) mod N_REQ.
  - busy_cnt is incremented by 1, wrapping at 2^32.
- No grant: rr_ptr is held. If resp_ready[out_id]=1, out_valid is cleared; otherwise the output is held stable.
- Latency: exactly 1 cycle from accept to resp_valid. Throughput is 1 op/cycle when the consumer keeps resp_ready high.
- resp_valid[i] = out_valid & (out_id==i). resp_data, resp_zero and resp_id stay stable while out_valid=1 and not consumed.
- resp_ready[j] with j != out_id is ignored.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- Requesters must hold req_valid and operands until req_ready. Dropping req_valid early is legal; that request is simply never granted.
- Opcodes 0..15 follow the ALU definition: and, or, add, xor, sll, srl, sub, slt, sge, passA, passB, eq, ne, sltu, sgeu, sra. Shift amount is B[4:0]. Opcodes 16..31 yield 0, Zero=1, illegal=1.
- Opcode 7 with A=0x80000000, B=1 returns 1 (signed compare). Add/sub wrap modulo 2^32 with no flag.

Decomposition:
- Shared package alu_pkg:
  - 5-bit opcode enum ALU_AND..ALU_SRA with values 0..15.
  - ALU_CTL_W=5 and XLEN=32.
  - Function is_legal_op.
- Sub-modules:
  - The existing ALU is instantiated once, unmodified.
  - rr_arbiter (parameterised N, rotate-priority one-hot grant, pointer update) is a natural, separately testable sub-module.

Test Plan:
- Reset mid-operation: accept add 5+7 for req0, assert rstn=0 before the consuming edge → resp_valid=0, busy_cnt=0 asynchronously; after release, a req2 request is granted with rr_ptr=0.
- Single requester: req1 add A=0xFFFFFFFF, B=1 → next cycle resp_valid=0010, resp_data=0, resp_zero=1, resp_id=1.
- All four valid continuously, resp_ready=all ones → grants 0,1,2,3,0,1... one per cycle; busy_cnt=8 after 8 cycles.
- Backpressure: req0 sub 3-5 held while resp_ready=0 for 3 cycles → resp_data=0xFFFFFFFE stable, req_ready=0 for all. Raising resp_ready[0] with req3 valid gives the req3 grant in the same cycle, and its result appears the next cycle.
- Shift/compare: req2 sra A=0x80000000, B=4 → 0xF8000000; opcode 7 A=0x80000000, B=1 → 1; opcode 13 with the same operands → 0.
- Illegal op: req3 ctl=20 → resp_data=0, resp_zero=1, resp_illegal=1, resp_id=3.
